// File: rtl/elastic_pkg.sv
// Shared constants and helpers for the elastic dataflow library.
package elastic_pkg;

  localparam int unsigned ELASTIC_N_OUT_DEF  = 4;
  localparam int unsigned ELASTIC_DATA_W_DEF = 8;

  // One valid/ready handshake pair.
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // Width of a bus carrying n lanes of w bits each.
  function automatic int unsigned bus_w(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

  // Low bit of lane idx in a bus of w-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/eager_fork_slot.sv
// One output lane of the eager fork: remembers whether this lane has taken
// the current head token and produces its valid, transfer and completion term.
module eager_fork_slot (
  input  logic clk,
  input  logic rst,
  input  logic tv,
  input  logic tm,
  input  logic n_ready,
  input  logic complete,
  output logic n_valid,
  output logic xfer,
  output logic term,
  output logic done
);

  logic done_q;
  logic done_d;

  always_comb begin
    n_valid = tv & tm & ~done_q;
    xfer    = n_valid & n_ready;
    term    = ~tm | done_q | xfer;
    done    = done_q;
    done_d  = complete ? 1'b0 : (done_q | xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/eager_fork_masked.sv
// Masked eager fork: broadcasts one token to the outputs selected by its mask.
// Define EAGER_FORK_INPUT_BUF_EN to insert a one-entry input register.
module eager_fork_masked
  import elastic_pkg::*;
#(
  parameter int unsigned N_OUT  = ELASTIC_N_OUT_DEF,
  parameter int unsigned DATA_W = ELASTIC_DATA_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 p_data,
  input  logic [N_OUT-1:0]                  p_mask,
  input  logic                              p_valid,
  output logic                              p_ready,
  output logic [bus_w(N_OUT, DATA_W)-1:0]   n_data,
  output logic [N_OUT-1:0]                  n_valid,
  input  logic [N_OUT-1:0]                  n_ready,
  output logic                              busy
);

  logic              tv;
  logic [DATA_W-1:0] td;
  logic [N_OUT-1:0]  tm;
  logic [N_OUT-1:0]  term;
  logic [N_OUT-1:0]  xfer;
  logic [N_OUT-1:0]  done;
  logic              complete;

`ifdef EAGER_FORK_INPUT_BUF_EN
  logic              full_q, full_d;
  logic [DATA_W-1:0] td_q, td_d;
  logic [N_OUT-1:0]  tm_q, tm_d;
  logic              load;

  // Opaque input register; a load and a completion may share a cycle.
  always_comb begin
    tv      = full_q;
    td      = td_q;
    tm      = tm_q;
    p_ready = ~full_q | complete;
    load    = p_valid & p_ready;
    full_d  = full_q;
    td_d    = td_q;
    tm_d    = tm_q;
    if (load) begin
      full_d = 1'b1;
      td_d   = p_data;
      tm_d   = p_mask;
    end else if (complete) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    td_q <= td_d;
    tm_q <= tm_d;
  end
`else
  always_comb begin
    tv      = p_valid;
    td      = p_data;
    tm      = p_mask;
    p_ready = complete;
  end
`endif

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    eager_fork_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .tv       (tv),
      .tm       (tm[i]),
      .n_ready  (n_ready[i]),
      .complete (complete),
      .n_valid  (n_valid[i]),
      .xfer     (xfer[i]),
      .term     (term[i]),
      .done     (done[i])
    );
  end

  // Token retires once every selected lane has taken it, now or earlier.
  always_comb begin
    complete = tv & (&term);
    busy     = |done;
    n_data   = {N_OUT{td}};
  end

endmodule

// File: tb/tb_eager_fork_masked.sv
// Scoreboard bench for eager_fork_masked; follows EAGER_FORK_INPUT_BUF_EN if defined.
module tb_eager_fork_masked;
  import elastic_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic [N-1:0] m;
  } tok_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   p_data = '0;
  logic [N-1:0]   p_mask = '0;
  logic           p_valid = 1'b0;
  logic           p_ready;
  logic [N*W-1:0] n_data;
  logic [N-1:0]   n_valid;
  logic [N-1:0]   n_ready = '0;
  logic           busy;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 1'b0;

  tok_t         exp_q[$];
  logic [N-1:0] delivered = '0;
  bit           in_reg = 1'b0;

  bit           vis, comp, exp_pr;
  logic [W-1:0] hd;
  logic [N-1:0] hm, exp_nv, xf, nd;

  eager_fork_masked #(.N_OUT(N), .DATA_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .p_data  (p_data),
    .p_mask  (p_mask),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .n_data  (n_data),
    .n_valid (n_valid),
    .n_ready (n_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the oldest outstanding token is the head; each selected
  // output must take it exactly once; it retires when the mask is covered.
  always @(negedge clk) begin
    if (rst) begin
      delivered = '0;
`ifdef EAGER_FORK_INPUT_BUF_EN
      if (in_reg) begin
        void'(exp_q.pop_front());
        in_reg = 1'b0;
      end
`endif
    end else begin
      vis = 1'b0;
      hd  = '0;
      hm  = '0;
`ifdef EAGER_FORK_INPUT_BUF_EN
      if (in_reg) begin
        vis = 1'b1;
        hd  = exp_q[0].d;
        hm  = exp_q[0].m;
      end
`else
      if (p_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: p_valid with no expected token at %0t", $time);
        end else begin
          vis = 1'b1;
          hd  = exp_q[0].d;
          hm  = exp_q[0].m;
        end
      end
`endif
      exp_nv = vis ? (hm & ~delivered) : '0;
      check("n_valid", 32'(n_valid), 32'(exp_nv));
      check("busy", 32'(busy), 32'(delivered != '0));
      xf = exp_nv & n_ready;
      for (int i = 0; i < N; i++) begin
        if (xf[i]) check($sformatf("n_data[%0d]", i), 32'(n_data[i*W +: W]), 32'(hd));
      end
      nd   = delivered | xf;
      comp = vis && ((hm & ~nd) == '0);
`ifdef EAGER_FORK_INPUT_BUF_EN
      exp_pr = !vis || comp;
`else
      exp_pr = comp;
`endif
      check("p_ready", 32'(p_ready), 32'(exp_pr));
      if (comp) begin
        void'(exp_q.pop_front());
        delivered = '0;
      end else begin
        delivered = nd;
      end
`ifdef EAGER_FORK_INPUT_BUF_EN
      if (p_valid && exp_pr) in_reg = 1'b1;
      else if (comp)         in_reg = 1'b0;
`endif
    end
  end

  // Producer must hold a stalled token stable.
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_d;
  logic [N-1:0]   prev_m;
  always @(posedge clk) begin
    if (!rst && prev_stall) begin
      assert (p_data == prev_d && p_mask == prev_m)
        else $error("producer changed a stalled token");
    end
    prev_stall <= p_valid & ~p_ready & ~rst;
    prev_d     <= p_data;
    prev_m     <= p_mask;
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      n_ready = N'($urandom);
    end
  end

  task automatic present(input logic [W-1:0] d, input logic [N-1:0] m);
    p_valid = 1'b1;
    p_data  = d;
    p_mask  = m;
    exp_q.push_back('{d: d, m: m});
  endtask

  task automatic wait_accept();
    bit got = 1'b0;
    int cnt = 0;
    while (!got && cnt < 200) begin
      @(negedge clk);
      got = p_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: got no p_ready expected p_ready within 200 cycles");
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic [N-1:0] m);
    present(d, m);
    wait_accept();
  endtask

  task automatic idle(input int k);
    p_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Full broadcast, all ready.
    n_ready = 4'b1111;
    send(8'hA5, 4'b1111);

    // Staggered ready.
    n_ready = 4'b0001;
    fork
      send(8'h3C, 4'b1111);
      begin
        @(posedge clk); #1; n_ready = 4'b0100;
        @(posedge clk); #1; n_ready = 4'b1010;
      end
    join
    n_ready = 4'b1111;
    idle(3);

    // Empty mask is dropped.
    n_ready = 4'b0000;
    send(8'h77, 4'b0000);
    idle(2);

    // Stalled partial mask.
    fork
      send(8'h96, 4'b0110);
      begin
        repeat (5) @(posedge clk);
        #1;
        n_ready = 4'b1111;
      end
    join
    idle(3);

    // Reset during partial delivery.
`ifdef EAGER_FORK_INPUT_BUF_EN
    n_ready = 4'b0000;
    send(8'h5A, 4'b1111);
    p_valid = 1'b0;
    n_ready = 4'b0011;
    @(posedge clk); #1;
    n_ready = 4'b0000;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
`else
    n_ready = 4'b0011;
    present(8'h5A, 4'b1111);
    @(posedge clk); #1;
    n_ready = 4'b0000;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_ready = 4'b1111;
    wait_accept();
    idle(2);
`endif

    // Back-to-back in-order tokens.
    n_ready = 4'b1111;
    for (int k = 0; k < 8; k++) send(W'(k), 4'b1111);
    idle(3);

    // Randomized traffic.
    rnd_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      send(W'($urandom), N'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    p_valid = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    n_ready = 4'b1111;
    idle(5);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
